// File: rtl/uart_rx_oversampler.sv
// UART receive deserializer driven by an oversampling tick: synchronizes i_rx,
// qualifies the start bit at mid-period and samples data/parity/stop mid-bit.
module uart_rx_oversampler #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_rx,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      armed_q    <= 1'b0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= i_rx;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      armed_q    <= armed_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  // Frame sequencing; everything advances only on oversampling ticks.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    armed_d    = armed_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_out_d = 1'b0;
    ferr_d     = 1'b0;
    busy_d     = busy_q;
    if (i_tick) begin
      case (state_q)
        S_IDLE: begin
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            tick_cnt_d = '0;
            armed_d    = 1'b0;
            busy_d     = 1'b1;
            par_en_d   = i_parity_en;
            par_odd_d  = i_parity_odd;
            state_d    = S_START;
          end
        end
        S_START: begin
          tick_cnt_d = tick_cnt_q + TW'(1);
          if (tick_cnt_q == HALF_M1) begin
            if (!rx_s) begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              state_d    = S_DATA;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          tick_cnt_d = tick_cnt_q + TW'(1);
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
        S_PARITY: begin
          tick_cnt_d = tick_cnt_q + TW'(1);
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            perr_d     = (^shreg_q) ^ rx_s ^ par_odd_q;
            state_d    = S_STOP;
          end
        end
        S_STOP: begin
          tick_cnt_d = tick_cnt_q + TW'(1);
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            data_d     = shreg_q;
            valid_d    = 1'b1;
            perr_out_d = par_en_q & perr_q;
            ferr_d     = ~rx_s;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler: table of single frames plus
// hand-written break, glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx_oversampler;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       i_rst, i_tick = 1'b0, i_rx, i_parity_en, i_parity_odd;
  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_frame_err, o_busy;

  uart_rx_oversampler #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_tick(i_tick), .i_rx(i_rx),
    .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd),
    .o_data(o_data), .o_valid(o_valid), .o_parity_err(o_parity_err),
    .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    longint     cyc;
  } rec_t;

  typedef struct {
    logic [7:0] d;
    logic       pen;
    logic       odd;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  int     n_vec = 0, n_err = 0;
  int     tick_per = 1, tick_ph = 0;
  longint cyc = 0, fall_cyc = 0, last_cyc = 0, busy_total = 0;
  rec_t   q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tick_ph >= tick_per - 1) begin
      i_tick  = 1'b1;
      tick_ph = 0;
    end else begin
      i_tick  = 1'b0;
      tick_ph = tick_ph + 1;
    end
  end

  always @(negedge clk) begin
    if (o_busy) busy_total <= busy_total + 1;
    if (o_valid) q.push_back('{o_data, o_parity_err, o_frame_err, cyc});
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    i_rx = b;
    repeat (n) @(negedge clk);
  endtask

  // Parity controls are flipped after the start bit to show they are latched.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic odd,
                            input logic pbit, input logic stop);
    int bt;
    bt = OS * tick_per;
    i_parity_en  = pen;
    i_parity_odd = odd;
    fall_cyc = cyc;
    drive_bit(1'b0, bt);
    i_parity_en  = ~pen;
    i_parity_odd = ~odd;
    for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
    if (pen) drive_bit(pbit, bt);
    drive_bit(stop, bt);
    i_parity_en  = pen;
    i_parity_odd = odd;
  endtask

  task automatic expect_frame(input string name, input logic [7:0] d,
                              input logic pe, input logic fe);
    rec_t r;
    check({name, "_count"}, q.size(), 1);
    if (q.size() > 0) begin
      r = q.pop_front();
      last_cyc = r.cyc;
      check({name, "_data"}, r.d, d);
      check({name, "_perr"}, r.pe, pe);
      check({name, "_ferr"}, r.fe, fe);
    end
    q.delete();
  endtask

  vec_t   tbl[7];
  rec_t   r3[3];
  longint b0;

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    tbl[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[4] = '{8'hC9, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC9, 1'b1, 1'b0};
    tbl[5] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
    tbl[6] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};

    i_rst = 1'b1; i_rx = 1'b1; i_parity_en = 1'b0; i_parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", o_data, 0);
    check("rst_valid", o_valid, 0);
    check("rst_perr", o_parity_err, 0);
    check("rst_ferr", o_frame_err, 0);
    check("rst_busy", o_busy, 0);
    i_rst = 1'b0;
    drive_bit(1'b1, 2 * OS);

    for (int v = 0; v < 7; v++) begin
      send_frame(tbl[v].d, tbl[v].pen, tbl[v].odd, tbl[v].pbit, tbl[v].stop);
      drive_bit(1'b1, 2 * OS);
      expect_frame($sformatf("vec%0d", v), tbl[v].exp_d, tbl[v].exp_pe, tbl[v].exp_fe);
      if (v == 0) check("latency", last_cyc - fall_cyc - 1, 154);
    end

    // Break: all-zero frame with low stop, line held low for 40 bit times.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 40 * OS);
    expect_frame("break", 8'h00, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * OS);
    check("break_rearm_count", q.size(), 0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * OS);
    expect_frame("after_break", 8'h3C, 1'b0, 1'b0);

    // Short low glitch: busy for exactly half a bit, no word delivered.
    b0 = busy_total;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 2 * OS);
    check("glitch_busy_cycles", busy_total - b0, 8);
    check("glitch_count", q.size(), 0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * OS);
    expect_frame("after_glitch", 8'h55, 1'b0, 1'b0);

    // Tick every 4th clock, three frames with no idle gap.
    tick_per = 4;
    drive_bit(1'b1, 2 * 4 * OS);
    q.delete();
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * 4 * OS);
    check("b2b_count", q.size(), 3);
    for (int i = 0; i < 3; i++) r3[i] = (q.size() > 0) ? q.pop_front() : '{8'hXX, 1'bx, 1'bx, 0};
    check("b2b_data0", r3[0].d, 8'h01);
    check("b2b_data1", r3[1].d, 8'h80);
    check("b2b_data2", r3[2].d, 8'hFF);
    check("b2b_err0", {r3[0].pe, r3[0].fe}, 0);
    check("b2b_space01", r3[1].cyc - r3[0].cyc, 640);
    check("b2b_space12", r3[2].cyc - r3[1].cyc, 640);
    q.delete();
    tick_per = 1;
    drive_bit(1'b1, 2 * OS);

    // Reset pulse in the middle of data bit 3 of frame 0xF0.
    i_parity_en = 1'b0;
    drive_bit(1'b0, OS);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, OS);
    drive_bit(1'b0, 8);
    check("pre_rst_busy", o_busy, 1);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("mid_rst_data", o_data, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_errs", {o_parity_err, o_frame_err}, 0);
    drive_bit(1'b0, 7);
    drive_bit(1'b1, 5 * OS);
    drive_bit(1'b1, 2 * OS);
    check("aborted_count", q.size(), 0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * OS);
    expect_frame("after_rst", 8'hC3, 1'b0, 1'b0);
    drive_bit(1'b1, 3 * OS);
    check("data_held", o_data, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
